// File: rtl/mem_axi_master.sv
// Load/store port that turns single CPU requests into AXI4-Lite read or write
// transactions toward the data cache, with lane steering and load extension.
module mem_axi_master #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP
    } state_t;

    state_t      state_q;
    logic        req_ready_q, resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] araddr_q, awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] rdata_q;

    logic        misalign_d, aw_done_d, w_done_d;
    logic [31:0] addr_al_d, wdata_d;
    logic [3:0]  wstrb_d;

    // Only bit 1 of the AXI response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    logic unused_resp_lsbs;
    assign unused_resp_lsbs = m_axi_rresp[0] ^ m_axi_bresp[0];

    function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'd0:    store_lanes = {4{d[7:0]}};
            2'd1:    store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    store_strobe = 4'b0001 << a;
            2'd1:    store_strobe = a[1] ? 4'b1100 : 4'b0011;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] size,
                                                 input logic [1:0] a, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    load_extract = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    load_extract = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: load_extract = d;
        endcase
    endfunction

    assign misalign_d = ALIGN_CHECK && ((req_size == 2'd1 && req_addr[0]) ||
                                        (req_size[1] && req_addr[1:0] != 2'b00));
    assign addr_al_d  = {req_addr[31:2], 2'b00};
    assign wdata_d    = store_lanes(req_wdata, req_size);
    assign wstrb_d    = store_strobe(req_size, req_addr[1:0]);
    assign aw_done_d  = !awvalid_q || m_axi_awready;
    assign w_done_d   = !wvalid_q || m_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= '0;
            lane_q       <= '0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        size_q      <= req_size;
                        sgn_q       <= req_signed;
                        lane_q      <= req_addr[1:0];
                        rdata_q     <= '0;
                        err_q       <= 1'b0;
                        if (misalign_d) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else if (req_we) begin
                            awaddr_q  <= addr_al_d;
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_ADDR_DATA;
                        end else begin
                            araddr_q  <= addr_al_d;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= m_axi_rdata;
                        err_q    <= m_axi_rresp[1];
                        state_q  <= RESP;
                    end
                end
                // Address and data handshakes complete independently, in any order.
                WR_ADDR_DATA: begin
                    if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready) wvalid_q <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        err_q    <= m_axi_bresp[1];
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (err_q || we_q) ? '0 : load_extract(rdata_q, size_q, lane_q, sgn_q);
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Bench for mem_axi_master: an AXI-Lite memory slave with programmable delays,
// and a byte-addressed reference memory that predicts every load/store result.
module tb_mem_axi_master;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;

    mem_axi_master #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration and observations
    int          ar_delay, r_delay, aw_delay, w_delay, b_delay;
    logic [1:0]  rresp_val, bresp_val;
    int          mon_ar_cycles, mon_activity;
    bit          mon_unstable, mon_bready_early;
    logic [31:0] mon_araddr, mon_awaddr, mon_wdata;
    logic [3:0]  mon_wstrb;

    logic [31:0] slv_mem [bit [29:0]];
    logic [7:0]  ref_mem [bit [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slv_read(input logic [31:0] a);
        if (slv_mem.exists(a[31:2])) return slv_mem[a[31:2]];
        return 32'd0;
    endfunction

    task automatic slv_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = slv_read(a);
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        slv_mem[a[31:2]] = w;
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'd0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        slv_mem[a[31:2]] = d;
        for (int i = 0; i < 4; i++) ref_mem[{a[31:2], 2'b00} + i] = d[8*i +: 8];
    endtask

    // Reference: an access of N bytes must sit on an N-byte boundary; memory is little-endian bytes.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] resp,
                         output logic [31:0] erd, output logic eerr, output bit mis);
        int nb;
        logic [31:0] v;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis  = (addr % nb) != 0;
        erd  = 32'd0;
        eerr = 1'b0;
        if (mis) begin
            eerr = 1'b1;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
            eerr = resp[1];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_byte(addr + i);
            if (sgn && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            eerr = resp[1];
            erd  = eerr ? 32'd0 : v;
        end
    endtask

    // AXI slave: acts at falling edges; p_* hold what the DUT samples at the next rising edge.
    initial begin : slave
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit r_pend, aw_done, w_done, b_pend;
        logic [31:0] rd_addr, wr_addr, wr_data;
        logic [3:0]  wr_strb;
        logic p_arvalid, p_arready, p_rvalid, p_rready, p_awvalid, p_awready;
        logic p_wvalid, p_wready, p_bvalid, p_bready;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
                m_axi_wready = 0; m_axi_bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                r_pend = 0; aw_done = 0; w_done = 0; b_pend = 0;
                p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0; p_awvalid = 0;
                p_awready = 0; p_wvalid = 0; p_wready = 0; p_bvalid = 0; p_bready = 0;
                p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
                continue;
            end
            if (p_arvalid && p_arready) begin
                rd_addr = p_araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0; m_axi_arready = 0;
            end
            if (p_rvalid && p_rready) begin m_axi_rvalid = 0; r_pend = 0; end
            if (p_bvalid && p_bready) begin m_axi_bvalid = 0; b_pend = 0; end
            if (p_awvalid && p_awready) begin
                wr_addr = p_awaddr; aw_done = 1; aw_cnt = 0; m_axi_awready = 0; mon_awaddr = p_awaddr;
            end
            if (p_wvalid && p_wready) begin
                wr_data = p_wdata; wr_strb = p_wstrb; w_done = 1; w_cnt = 0; m_axi_wready = 0;
                mon_wdata = p_wdata; mon_wstrb = p_wstrb;
            end
            if (aw_done && w_done) begin
                slv_write(wr_addr, wr_data, wr_strb);
                aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
            end
            if (m_axi_bready && !b_pend) mon_bready_early = 1;
            if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) mon_activity++;
            if (m_axi_arvalid) begin
                mon_ar_cycles++;
                if (p_arvalid && !p_arready && m_axi_araddr !== p_araddr) mon_unstable = 1;
                mon_araddr = m_axi_araddr;
            end
            if (m_axi_awvalid && p_awvalid && !p_awready && m_axi_awaddr !== p_awaddr) mon_unstable = 1;
            if (m_axi_wvalid && p_wvalid && !p_wready &&
                (m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb)) mon_unstable = 1;
            if (m_axi_arvalid && !m_axi_arready) begin
                if (ar_cnt >= ar_delay) m_axi_arready = 1; else ar_cnt++;
            end
            if (r_pend && !m_axi_rvalid) begin
                if (r_cnt >= r_delay) begin
                    m_axi_rvalid = 1; m_axi_rdata = slv_read(rd_addr); m_axi_rresp = rresp_val;
                end else r_cnt++;
            end
            if (m_axi_awvalid && !m_axi_awready && !aw_done) begin
                if (aw_cnt >= aw_delay) m_axi_awready = 1; else aw_cnt++;
            end
            if (m_axi_wvalid && !m_axi_wready && !w_done) begin
                if (w_cnt >= w_delay) m_axi_wready = 1; else w_cnt++;
            end
            if (b_pend && !m_axi_bvalid) begin
                if (b_cnt >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = bresp_val; end
                else b_cnt++;
            end
            p_arvalid = m_axi_arvalid; p_arready = m_axi_arready; p_araddr = m_axi_araddr;
            p_rvalid = m_axi_rvalid; p_rready = m_axi_rready;
            p_awvalid = m_axi_awvalid; p_awready = m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wvalid = m_axi_wvalid; p_wready = m_axi_wready; p_wdata = m_axi_wdata;
            p_wstrb = m_axi_wstrb; p_bvalid = m_axi_bvalid; p_bready = m_axi_bready;
        end
    end

    // Called at a falling edge; returns at the falling edge after the response cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 0;
        mon_ar_cycles = 0; mon_activity = 0; mon_unstable = 0; mon_bready_early = 0;
        mon_araddr = 0; mon_awaddr = 0; mon_wdata = 0; mon_wstrb = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("req_ready_busy", req_ready, 0);
        end while (resp_valid !== 1'b1 && lat < 100);
        check("resp_seen", resp_valid, 1);
        rd  = resp_rdata;
        err = resp_err;
        @(negedge clk);
        check("resp_pulse", resp_valid, 0);
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
        logic [31:0] erd;
        logic        eerr;
        bit          mis;
        int          elat;
        model(we, size, sgn, addr, wd, we ? bresp_val : rresp_val, erd, eerr, mis);
        elat = mis ? 2 : we ? 4 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                            : 4 + ar_delay + r_delay;
        do_req(we, size, sgn, addr, wd, rd, err, lat);
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
        check({tag, "_latency"}, lat, elat);
        if (mis) begin
            check({tag, "_no_bus"}, mon_activity, 0);
        end else if (we) begin
            check({tag, "_awaddr"}, mon_awaddr, addr & 32'hFFFF_FFFC);
            check({tag, "_bready_order"}, {31'd0, mon_bready_early}, 0);
            check({tag, "_stable"}, {31'd0, mon_unstable}, 0);
        end else begin
            check({tag, "_araddr"}, mon_araddr, addr & 32'hFFFF_FFFC);
            check({tag, "_stable"}, {31'd0, mon_unstable}, 0);
        end
    endtask

    initial begin : main
        logic [31:0] rd, addr, wd;
        logic        err, we, sgn;
        logic [1:0]  size;
        int          lat, w;
        rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        rresp_val = 0; bresp_val = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_awaddr", m_axi_awaddr, 0);
        check("rst_wdata", m_axi_wdata, 0);
        check("rst_wstrb", m_axi_wstrb, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);

        // Word load with slow address acceptance
        preload(32'h0000_1004, 32'hDEAD_BEEF);
        ar_delay = 5;
        run("wload", 0, 2'd2, 0, 32'h0000_1004, 0, rd, err, lat);
        check("wload_value", rd, 32'hDEAD_BEEF);
        check("wload_ar_cycles", mon_ar_cycles, 6);
        ar_delay = 0;

        // Byte load, signed then unsigned
        preload(32'h0000_2000, 32'h80FF_1234);
        run("bload_s", 0, 2'd0, 1, 32'h0000_2003, 0, rd, err, lat);
        check("bload_s_value", rd, 32'hFFFF_FF80);
        check("bload_s_min_lat", lat, 4);
        run("bload_u", 0, 2'd0, 0, 32'h0000_2003, 0, rd, err, lat);
        check("bload_u_value", rd, 32'h0000_0080);

        // Half store with data accepted before address, then read back
        aw_delay = 3; w_delay = 0;
        run("hstore", 1, 2'd1, 0, 32'h0000_3002, 32'h1234_ABCD, rd, err, lat);
        check("hstore_awaddr", mon_awaddr, 32'h0000_3000);
        check("hstore_wdata", mon_wdata, 32'hABCD_ABCD);
        check("hstore_wstrb", {28'd0, mon_wstrb}, 32'hC);
        aw_delay = 0;
        run("hload", 0, 2'd1, 1, 32'h0000_3002, 0, rd, err, lat);
        check("hload_value", rd, 32'hFFFF_ABCD);

        // Misaligned word load
        run("misalign", 0, 2'd2, 0, 32'h0000_0006, 0, rd, err, lat);
        check("misalign_err", {31'd0, err}, 1);

        // Store answered with SLVERR, then an immediate follow-up request
        bresp_val = 2'b10;
        run("bstore_err", 1, 2'd0, 0, 32'h0000_0011, 32'h0000_005A, rd, err, lat);
        check("bstore_err_flag", {31'd0, err}, 1);
        check("bstore_err_wstrb", {28'd0, mon_wstrb}, 32'h2);
        bresp_val = 2'b00;
        check("accept_after_resp", req_ready, 1);
        run("after_err", 0, 2'd0, 0, 32'h0000_0011, 0, rd, err, lat);

        // Reset while waiting for read data
        r_delay = 20;
        req_valid = 1; req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 0;
        w = 0;
        do begin @(negedge clk); w++; end while (m_axi_rready !== 1'b1 && w < 20);
        check("rst_mid_reached", m_axi_rready, 1);
        rst = 1;
        @(negedge clk);
        check("rst_mid_arvalid", m_axi_arvalid, 0);
        check("rst_mid_rready", m_axi_rready, 0);
        check("rst_mid_resp_valid", resp_valid, 0);
        check("rst_mid_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_mid_ready_back", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        r_delay = 0;

        // Randomized traffic in a 64-byte window
        for (int t = 0; t < 80; t++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 63));
            wd   = $urandom;
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3);
            rresp_val = ($urandom_range(0, 5) == 0) ? {1'b1, 1'($urandom_range(0, 1))}
                                                    : {1'b0, 1'($urandom_range(0, 1))};
            bresp_val = ($urandom_range(0, 5) == 0) ? {1'b1, 1'($urandom_range(0, 1))}
                                                    : {1'b0, 1'($urandom_range(0, 1))};
            run("rand", we, size, sgn, addr, wd, rd, err, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_axi_master.md
Name: mem_axi_master

Overview:
- CPU-side load/store port that drives the AXI4-Lite-style slave interface of the 1 MB data cache (the m_axi_* side of the cache).
- Accepts one load or store request at a time, with byte, halfword or word size.
- Generates word-aligned AXI addresses, write-data lane replication and write strobes.
- Performs read-lane extraction with sign or zero extension, and returns a single-cycle response pulse.

Parameters:
- ALIGN_CHECK, 1: 1 = misaligned requests complete immediately with resp_err=1 and no bus traffic; 0 = low address bits beyond the access size are ignored (access forced aligned).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  block idle, can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_signed  in  1  loads: sign-extend when 1, zero-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misalignment or SLVERR/DECERR; valid with resp_valid
- m_axi_araddr  out  32
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  32
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axi_awaddr  out  32
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE; req_ready=0 during rst, 1 the cycle after; all m_axi_* valid/ready outputs 0; addresses, wdata and wstrb 0; resp_valid=0; resp_rdata=0; resp_err=0.
- rst asserted mid-transaction: all of the above apply on the next edge and the transaction is abandoned (no response). The cache has no reset, so system reset must cover both blocks.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch addr, size, signed, we and wdata; req_ready drops the next cycle.
  - Misaligned (ALIGN_CHECK=1): half with addr[0]=1, or word with addr[1:0]≠0 → RESP with err=1, rdata=0. No AXI activity.
  - Load → RD_ADDR with m_axi_araddr={addr[31:2],2'b00} and arvalid=1.
  - Store → WR_ADDR_DATA with awaddr aligned the same way, awvalid=1, wvalid=1, wdata and wstrb formed as below.
- RD_ADDR: hold arvalid and araddr stable until arready is sampled high. Then arvalid=0, rready=1 → RD_DATA.
- RD_DATA: on rvalid, rready=0, capture rdata and rresp → RESP.
- WR_ADDR_DATA:
  - awvalid drops the cycle after awready is sampled high; wvalid drops the cycle after wready is sampled high. The two handshakes are independent and may occur in either order or together.
  - Once both have completed, bready=1 → WR_RESP.
  - Payloads stay stable while their valid is high.
- WR_RESP: on bvalid, bready=0, capture bresp → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_err = resp[1] of the captured rresp/bresp.
  - Request-to-response minimum is 4 cycles for loads and 4 for stores when the slave is ready immediately; the misalign path takes 2 cycles.
- Store lanes, with a = addr[1:0]:
  - byte: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<a.
  - half: wdata={2{wdata[15:0]}}, wstrb = a[1] ? 4'b1100 : 4'b0011.
  - word: wdata unchanged, wstrb=4'b1111.
- Load extraction:
  - byte: lane = rdata[8a+7:8a].
  - half: lane = rdata[16a[1]+15:16a[1]].
  - The lane is then sign- or zero-extended to 32 bits per req_signed.
  - Word loads pass rdata unchanged.
  - On error, resp_rdata=0.
- req_valid is ignored outside IDLE. At most one outstanding transaction. Valid is never dropped before its handshake.

Test Plan:
- Word load at 0x0000_1004, arready delayed 5 cycles, rdata=0xDEADBEEF, rresp=0 → araddr=0x0000_1004 held 6 cycles; resp_rdata=0xDEADBEEF, err=0, one-cycle resp_valid.
- Signed byte load at 0x0000_2003, rdata=0x80FF_1234 → resp_rdata=0xFFFF_FF80; same request with req_signed=0 → 0x0000_0080.
- Half store 0xABCD at 0x0000_3002 with wready before awready, bresp=0 → awaddr=0x0000_3000, wdata=0xABCD_ABCD, wstrb=4'b1100; bready asserts only after both handshakes; err=0.
- Word load at 0x0000_0006 with ALIGN_CHECK=1 → no arvalid; resp_valid 2 cycles after accept with err=1, rdata=0.
- Byte store with bresp=2'b10 → resp_err=1; next request accepted the cycle after the response.
- rst pulsed while in RD_DATA → arvalid, rready and resp_valid are 0 the next cycle; req_ready=1 the cycle after rst deasserts.
